ma_data_mem_ws: RTL and testbench

Parametrised data-memory unit for the MEM stage of the ARM pipeline. It adds byte, halfword and word access with sign or zero extension, a configurable base address, depth and wait-state count, and a stall/ready handshake toward the hazard/freeze logic. Out-of-range and misaligned accesses are detected and flagged instead of silently aliasing. It sits between EXE_MEM and MEM_WB registers; `stall` feeds the pipeline freeze.

---
 rtl/ma_data_mem_ws_pkg.sv | 16 +
 rtl/ma_data_mem_ws_lane_align.sv | 47 ++++
 rtl/ma_data_mem_ws.sv | 110 +++++++++++
 tb/tb_ma_data_mem_ws.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_data_mem_ws_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states
// and the default placement of the memory in the byte address space.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/ma_data_mem_ws_lane_align.sv
// Little-endian byte-lane steering: extracts and extends sub-word load data,
// and merges sub-word store data into the currently stored word.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic        [7:0]  ld_byte;
  logic        [15:0] ld_half;
  logic signed [7:0]  ld_byte_s;
  logic signed [15:0] ld_half_s;

  always_comb begin
    ld_byte   = rd_word[{lane, 3'b000} +: 8];
    ld_half   = rd_word[{lane[1], 4'b0000} +: 16];
    ld_byte_s = ld_byte;
    ld_half_s = ld_half;
    ld_data   = '0;
    case (size)
      SZ_BYTE: ld_data = sign_ext ? DATA_W'(ld_byte_s) : DATA_W'(ld_byte);
      SZ_HALF: ld_data = sign_ext ? DATA_W'(ld_half_s) : DATA_W'(ld_half);
      SZ_WORD: ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Untouched lanes keep their stored value, so sub-word stores are a single-edge RMW.
  always_comb begin
    st_word = rd_word;
    case (size)
      SZ_BYTE: st_word[{lane, 3'b000} +: 8]     = wr_data[7:0];
      SZ_HALF: st_word[{lane[1], 4'b0000} +: 16] = wr_data[15:0];
      SZ_WORD: st_word = wr_data;
      default: st_word = rd_word;
    endcase
  end

endmodule

// File: rtl/ma_data_mem_ws.sv
// MEM-stage data memory with byte/half/word access, configurable wait states
// and a stall handshake; bad addresses are flagged rather than aliased.
module ma_data_mem_ws
  import mem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mem_result,
  output logic              ready,
  output logic              stall,
  output logic              addr_err
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              range_err;
  logic              align_err;
  logic              err;
  logic              commit;
  logic [29:0]       widx;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  assign req = mem_r_en | mem_w_en;

  // BASE_ADDR is word-aligned, so the word index can be formed from bits [31:2] alone.
  assign widx      = address[31:2] - BASE_ADDR[31:2];
  assign idx       = widx[IDX_W-1:0];
  assign range_err = (address < BASE_ADDR) || (widx >= DEPTH_W);

  always_comb begin
    align_err = 1'b0;
    case (size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = address[0];
      SZ_WORD: align_err = (address[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

  assign err     = range_err | align_err;
  assign rd_word = mem[idx];

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size     (size),
    .lane     (address[1:0]),
    .sign_ext (sign_ext),
    .rd_word  (rd_word),
    .wr_data  (data),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  assign ready      = (WAIT_CYCLES == 0) ? req : (req && (state == BUSY) && (cnt == CNT_LAST));
  assign stall      = req & ~ready;
  assign addr_err   = ready & err;
  assign commit     = ready & mem_w_en & ~err;
  assign mem_result = (ready && mem_r_en && !mem_w_en && !err) ? ld_data : '0;

  // Access FSM: IDLE accepts a request, BUSY counts wait states until completion or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (commit) mem[idx] <= st_word;
      case (state)
        IDLE: begin
          if (req && (WAIT_CYCLES > 0)) begin
            state <= BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (!req || ready) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_data_mem_ws.sv
// Scoreboard bench: two builds (2 wait states and 0 wait states) checked
// against a byte-addressed reference memory.
module tb_ma_data_mem_ws;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          NBYTE = DEPTH * 4;

  typedef struct packed {
    logic        err;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        r2, w2, sx2;
  logic [1:0]  sz2;
  logic [31:0] a2, d2;
  logic [31:0] res2;
  logic        ready2, stall2, aerr2;

  logic        r0, w0, sx0;
  logic [1:0]  sz0;
  logic [31:0] a0, d0;
  logic [31:0] res0;
  logic        ready0, stall0, aerr0;

  int   checks = 0;
  int   errors = 0;
  exp_t q2[$];
  exp_t q0[$];
  logic [7:0] mdl [2][NBYTE];

  always #5 clk = ~clk;

  ma_data_mem_ws #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_r_en(r2), .mem_w_en(w2), .size(sz2), .sign_ext(sx2),
    .address(a2), .data(d2), .mem_result(res2), .ready(ready2), .stall(stall2), .addr_err(aerr2)
  );

  ma_data_mem_ws #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0), .size(sz0), .sign_ext(sx0),
    .address(a0), .data(d0), .mem_result(res0), .ready(ready0), .stall(stall0), .addr_err(aerr0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_models();
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < NBYTE; b++) mdl[m][b] = 8'h00;
  endtask

  // Reference: byte-addressed memory; an access of n bytes must be n-aligned and in range.
  task automatic predict(input int m, input logic r, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d,
                         output logic e_err, output logic [31:0] e_res);
    int unsigned n, off;
    logic [63:0] mask;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_err = (a < BASE) || (a >= BASE + NBYTE) || (sz == 2'd3) || ((a % n) != 0);
    e_res = 32'h0;
    if (!e_err) begin
      off = a - BASE;
      if (w) begin
        for (int i = 0; i < int'(n); i++) mdl[m][off + i] = d[8*i +: 8];
      end else if (r) begin
        for (int i = 0; i < int'(n); i++) e_res = e_res | (32'(mdl[m][off + i]) << (8 * i));
        mask = (64'd1 << (8 * n)) - 64'd1;
        if (sx && e_res[8*n-1]) e_res = e_res | ~mask[31:0];
      end
    end
  endtask

  task automatic acc2(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit use_c = 1'b0, input logic [31:0] c_res = 32'h0, input logic c_err = 1'b0);
    logic e_err;
    logic [31:0] e_res;
    int cyc;
    predict(0, r, w, sz, sx, a, d, e_err, e_res);
    @(posedge clk); #1;
    r2 = r; w2 = w; sz2 = sz; sx2 = sx; a2 = a; d2 = d;
    q2.push_back(use_c ? exp_t'({c_err, c_res}) : exp_t'({e_err, e_res}));
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      if (ready2) break;
      chk("stall2_wait", 32'(stall2), 32'd1);
      cyc++;
    end
    chk("latency2", cyc, 32'd2);
    chk("stall2_done", 32'(stall2), 32'd0);
  endtask

  task automatic acc0(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit use_c = 1'b0, input logic [31:0] c_res = 32'h0, input logic c_err = 1'b0);
    logic e_err;
    logic [31:0] e_res;
    predict(1, r, w, sz, sx, a, d, e_err, e_res);
    @(posedge clk); #1;
    r0 = r; w0 = w; sz0 = sz; sx0 = sx; a0 = a; d0 = d;
    q0.push_back(use_c ? exp_t'({c_err, c_res}) : exp_t'({e_err, e_res}));
    @(negedge clk);
    chk("ready0_same_cycle", 32'(ready0), 32'd1);
    chk("stall0", 32'(stall0), 32'd0);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    r2 = 1'b0; w2 = 1'b0; r0 = 1'b0; w0 = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic rand_op(output logic r, output logic w, output logic [1:0] sz, output logic sx,
                         output logic [31:0] a, output logic [31:0] d);
    int unsigned k, n;
    k  = $urandom_range(0, 3);
    w  = (k == 0) || (k == 2);
    r  = (k != 0);
    k  = $urandom_range(0, 7);
    sz = (k < 2) ? 2'd0 : (k < 4) ? 2'd1 : (k < 7) ? 2'd2 : 2'd3;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a  = 32'd1016 + $urandom_range(0, 280);
    if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
    sx = 1'($urandom_range(0, 1));
    d  = $urandom;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready2_unexpected: got ready=1, expected no completion at %0t", $time);
        end else begin
          e = q2.pop_front();
          chk("result2", res2, e.res);
          chk("addr_err2", 32'(aerr2), 32'(e.err));
        end
      end else begin
        chk("idle_result2", res2, 32'h0);
        chk("idle_addr_err2", 32'(aerr2), 32'd0);
      end
      if (ready0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready0_unexpected: got ready=1, expected no completion at %0t", $time);
        end else begin
          e = q0.pop_front();
          chk("result0", res0, e.res);
          chk("addr_err0", 32'(aerr0), 32'(e.err));
        end
      end
    end
  endtask

  task automatic run_tests();
    logic r, w, sx;
    logic [1:0] sz;
    logic [31:0] a, d;

    acc2(1, 0, 2'd2, 0, 32'd1024, 32'h0, 1, 32'h0000_0000, 0);
    acc2(0, 1, 2'd2, 0, 32'd1028, 32'h8899_AABB);
    acc2(1, 0, 2'd0, 1, 32'd1029, 32'h0, 1, 32'hFFFF_FFAA, 0);
    acc2(1, 0, 2'd0, 0, 32'd1029, 32'h0, 1, 32'h0000_00AA, 0);
    acc2(1, 0, 2'd1, 1, 32'd1030, 32'h0, 1, 32'hFFFF_8899, 0);
    acc2(0, 1, 2'd0, 0, 32'd1031, 32'hFFFF_FF11);
    acc2(1, 0, 2'd2, 0, 32'd1028, 32'h0, 1, 32'h1199_AABB, 0);
    acc2(1, 0, 2'd2, 0, 32'd1020, 32'h0, 1, 32'h0, 1);
    acc2(0, 1, 2'd2, 0, 32'd1280, 32'hDEAD_BEEF, 1, 32'h0, 1);
    acc2(1, 0, 2'd1, 1, 32'd1025, 32'h0, 1, 32'h0, 1);
    acc2(0, 1, 2'd2, 0, 32'd1026, 32'hCAFE_F00D, 1, 32'h0, 1);
    acc2(0, 1, 2'd3, 0, 32'd1024, 32'h5555_5555, 1, 32'h0, 1);
    acc2(1, 1, 2'd2, 0, 32'd1040, 32'hA5A5_0F0F, 1, 32'h0, 0);
    acc2(1, 0, 2'd2, 0, 32'd1024, 32'h0, 1, 32'h0000_0000, 0);
    acc2(1, 0, 2'd2, 0, 32'd1040, 32'h0, 1, 32'hA5A5_0F0F, 0);

    // Abort: drop the write enable while the access is still waiting.
    @(posedge clk); #1;
    r2 = 0; w2 = 1; sz2 = 2'd2; a2 = 32'd1032; d2 = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("abort_stall_c0", 32'(stall2), 32'd1);
    @(posedge clk); #1;
    w2 = 0;
    @(negedge clk);
    chk("abort_ready_c1", 32'(ready2), 32'd0);
    chk("abort_stall_c1", 32'(stall2), 32'd0);
    acc2(1, 0, 2'd2, 0, 32'd1032, 32'h0, 1, 32'h0, 0);

    // Reset lands in the middle of a pending write.
    @(posedge clk); #1;
    r2 = 0; w2 = 1; sz2 = 2'd2; a2 = 32'd1032; d2 = 32'hDEAD_BEEF;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rst_ready", 32'(ready2), 32'd0);
    chk("rst_stall_eq_req", 32'(stall2), 32'd1);
    chk("rst_addr_err", 32'(aerr2), 32'd0);
    chk("rst_result", res2, 32'h0);
    @(posedge clk); #1;
    rst = 0; w2 = 0;
    clear_models();
    acc2(1, 0, 2'd2, 0, 32'd1032, 32'h0, 1, 32'h0, 0);
    acc2(1, 0, 2'd2, 0, 32'd1028, 32'h0, 1, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      rand_op(r, w, sz, sx, a, d);
      acc2(r, w, sz, sx, a, d);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Zero-wait-state build: back-to-back write then read.
    acc0(0, 1, 2'd2, 0, 32'd1036, 32'h1234_5678);
    acc0(1, 0, 2'd2, 0, 32'd1036, 32'h0, 1, 32'h1234_5678, 0);
    acc0(1, 0, 2'd1, 1, 32'd1038, 32'h0, 1, 32'h0000_1234, 0);
    acc0(1, 0, 2'd2, 0, 32'd1037, 32'h0, 1, 32'h0, 1);
    for (int i = 0; i < 60; i++) begin
      rand_op(r, w, sz, sx, a, d);
      acc0(r, w, sz, sx, a, d);
    end
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    r2 = 0; w2 = 0; sz2 = 0; sx2 = 0; a2 = 0; d2 = 0;
    r0 = 0; w0 = 0; sz0 = 0; sx0 = 0; a0 = 0; d0 = 0;
    clear_models();
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready2), 32'd0);
    chk("reset_stall", 32'(stall2), 32'd0);
    chk("reset_addr_err", 32'(aerr2), 32'd0);
    chk("reset_result", res2, 32'h0);
    r2 = 1;
    #1;
    chk("reset_stall_req", 32'(stall2), 32'd1);
    chk("reset_ready_req", 32'(ready2), 32'd0);
    r2 = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    fork
      monitor();
      run_tests();
      begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_any

    chk("queue2_drained", q2.size(), 32'd0);
    chk("queue0_drained", q0.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
